deal_cards: RTL and testbench

Writer-side companion to the card-memory compare path. On `start`, it deals a freshly shuffled deck of 18 value pairs (36 cards) into the 6x6 region (addresses 0–35) of the 64-entry card memory through that memory's write port. Shuffling uses a free-running 16-bit LFSR with linear probing into an occupancy bitmap. The compare logic and display read the memory only after `done` is high.

---
 rtl/deal_cards.sv | 114 +++++++++++
 tb/tb_deal_cards.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deal_cards.sv
// deal_cards: deals a shuffled deck of value pairs into the card memory.
// LFSR-picked positions, linear probing over an occupancy bitmap.
module deal_cards #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          NUM_CARDS = 36
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       wEn,
    output logic [5:0] wAddr,
    output logic [4:0] wData,
    output logic       busy,
    output logic       done
);

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [5:0]  LAST     = 6'(NUM_CARDS - 1);
    localparam logic [6:0]  NUM7     = 7'(NUM_CARDS);

    typedef enum logic [1:0] {
        IDLE,
        PICK,
        PROBE
    } state_t;

    state_t                 state;
    logic [15:0]            lfsr;
    logic                   fb;
    logic [NUM_CARDS-1:0]   occ;
    logic [5:0]             card;
    logic [5:0]             pos;
    logic [6:0]             mod7;
    logic [5:0]             cand;
    logic                   fin;

    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Fold the low six LFSR bits into the dealt region.
    always_comb begin
        mod7 = {1'b0, lfsr[5:0]} % NUM7;
        cand = mod7[5:0];
    end

    // Free-running LFSR, advances every cycle regardless of state.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= {lfsr[14:0], fb};
        end
    end

    // Deal FSM: pick a slot, probe forward past taken slots, write.
    // fin marks the cycle carrying the final write so done rises after it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            occ   <= '0;
            card  <= '0;
            pos   <= '0;
            fin   <= 1'b0;
            wEn   <= 1'b0;
            wAddr <= '0;
            wData <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            wEn <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        occ   <= '0;
                        card  <= '0;
                        fin   <= 1'b0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= PICK;
                    end else if (fin) begin
                        fin  <= 1'b0;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                PICK: begin
                    pos   <= cand;
                    state <= PROBE;
                end
                PROBE: begin
                    if (occ[pos]) begin
                        pos <= (pos == LAST) ? 6'd0 : pos + 6'd1;
                    end else begin
                        wEn      <= 1'b1;
                        wAddr    <= pos;
                        wData    <= card[5:1];
                        occ[pos] <= 1'b1;
                        if (card == LAST) begin
                            fin   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            card  <= card + 6'd1;
                            state <= PICK;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deal_cards.sv
// tb_deal_cards: two dealers (seed ACE1 and seed 0) against a deck model.
// Model plans each whole deal from the LFSR sequence at start time.
module tb_deal_cards;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic [1:0]      d_wen;
    logic [1:0]      d_busy;
    logic [1:0]      d_done;
    logic [1:0][5:0] d_addr;
    logic [1:0][4:0] d_data;

    always #5 clk = ~clk;

    deal_cards #(.SEED(16'hACE1)) dut_a (
        .clock(clk), .reset(reset), .start(start),
        .wEn(d_wen[0]), .wAddr(d_addr[0]), .wData(d_data[0]),
        .busy(d_busy[0]), .done(d_done[0])
    );

    deal_cards #(.SEED(16'h0000)) dut_z (
        .clock(clk), .reset(reset), .start(start),
        .wEn(d_wen[1]), .wAddr(d_addr[1]), .wData(d_data[1]),
        .busy(d_busy[1]), .done(d_done[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit armed = 0;

    logic [15:0] seed_eff [2] = '{16'hACE1, 16'h0001};
    logic [15:0] ml [2];
    bit  have [2];
    int  acc [2];
    int  fin [2];
    int  nxt [2];
    int  wcyc [2][36];
    int  wadr [2][36];
    bit  wwrap [2][36];
    int  wraps [2];
    logic       e_wen [2];
    logic       e_busy [2];
    logic       e_done [2];
    logic [5:0] e_addr [2];
    logic [4:0] e_data [2];

    int          wcnt [2];
    int          total_w [2];
    int          deals [2];
    logic [63:0] mask [2];
    bit          got_first [2];
    int          first_addr [2];
    logic        p_busy [2];
    logic        p_done [2];

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic int cand(input logic [15:0] l);
        int v;
        v = int'(l[5:0]);
        return (v < 36) ? v : v - 36;
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d got %0h want %0h",
                     nm, i, cyc, act, exp);
        end
    endtask

    // Whole-deal plan: walk the LFSR forward to each pick cycle,
    // probe linearly through the occupancy set, record write cycles.
    task automatic plan(input int i);
        logic [15:0] tl;
        logic [35:0] occ;
        int tt;
        int t;
        int a;
        int p;
        tl  = ml[i];
        tt  = cyc;
        t   = cyc + 1;
        occ = '0;
        for (int k = 0; k < 36; k++) begin
            while (tt < t) begin
                tl = step(tl);
                tt++;
            end
            a = cand(tl);
            p = 0;
            wwrap[i][k] = 0;
            while (occ[a]) begin
                if (a == 35) begin
                    wwrap[i][k] = 1;
                    a = 0;
                end else begin
                    a++;
                end
                p++;
            end
            occ[a] = 1'b1;
            wadr[i][k] = a;
            t = t + 2 + p;
            wcyc[i][k] = t;
        end
        acc[i]  = cyc;
        fin[i]  = wcyc[i][35];
        have[i] = 1;
        nxt[i]  = 0;
    endtask

    always @(posedge clk) begin : model
        int c;
        c = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                ml[i]     = seed_eff[i];
                have[i]   = 0;
                nxt[i]    = 0;
                e_addr[i] = '0;
                e_data[i] = '0;
            end else begin
                if (start && !(have[i] && cyc > acc[i] && cyc < fin[i]))
                    plan(i);
                ml[i] = step(ml[i]);
            end
            e_wen[i] = 1'b0;
            if (have[i] && nxt[i] < 36 && wcyc[i][nxt[i]] == c) begin
                e_wen[i]  = 1'b1;
                e_addr[i] = 6'(wadr[i][nxt[i]]);
                e_data[i] = 5'(nxt[i] >> 1);
                if (wwrap[i][nxt[i]]) wraps[i]++;
                nxt[i]++;
            end
            e_busy[i] = have[i] && c > acc[i] && c <= fin[i];
            e_done[i] = have[i] && c > fin[i];
        end
        cyc   = c;
        armed = 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                chk("wEn", i, 64'(d_wen[i]), 64'(e_wen[i]));
                chk("wAddr", i, 64'(d_addr[i]), 64'(e_addr[i]));
                chk("wData", i, 64'(d_data[i]), 64'(e_data[i]));
                chk("busy", i, 64'(d_busy[i]), 64'(e_busy[i]));
                chk("done", i, 64'(d_done[i]), 64'(e_done[i]));
                if (d_busy[i] && !p_busy[i]) begin
                    wcnt[i] = 0;
                    mask[i] = '0;
                end
                if (d_wen[i]) begin
                    chk("dup_addr", i, 64'(mask[i][d_addr[i]]), 64'd0);
                    mask[i][d_addr[i]] = 1'b1;
                    wcnt[i]++;
                    total_w[i]++;
                    if (!got_first[i]) begin
                        got_first[i]  = 1;
                        first_addr[i] = int'(d_addr[i]);
                    end
                end
                if (d_done[i] && !p_done[i]) begin
                    chk("deal_count", i, 64'(wcnt[i]), 64'd36);
                    chk("deal_set", i, mask[i], 64'h0000_000F_FFFF_FFFF);
                    deals[i]++;
                end
                p_busy[i] = d_busy[i];
                p_done[i] = d_done[i];
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic wait_wens(input int n);
        int seen;
        int budget;
        seen = 0;
        budget = 2000;
        while (seen < n && budget > 0) begin
            @(posedge clk);
            #2;
            if (d_wen[0]) seen++;
            budget--;
        end
        chk("wait_wen", 0, 64'(seen), 64'(n));
    endtask

    task automatic wait_done();
        int budget;
        budget = 1600;
        while (d_done != 2'b11 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        chk("wait_done", 0, 64'(d_done), 64'h3);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog cyc %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : drive
        logic [15:0] pl;
        int snap [2];
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wraps[i] = 0; wcnt[i] = 0; total_w[i] = 0; deals[i] = 0;
            mask[i] = '0; got_first[i] = 0; first_addr[i] = -1;
            p_busy[i] = 1'b0; p_done[i] = 1'b0;
        end

        pl = 16'hACE1;
        chk("pin_step_ace1", 0, 64'(step(pl)), 64'h59C3);
        pl = 16'h0400;
        chk("pin_step_fb", 0, 64'(step(pl)), 64'h0801);
        pl = 16'd63;
        chk("pin_cand63", 0, 64'(cand(pl)), 64'd27);
        pl = 16'd36;
        chk("pin_cand36", 0, 64'(cand(pl)), 64'd0);
        pl = 16'h3879;
        chk("pin_cand57", 0, 64'(cand(pl)), 64'd21);

        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_wEn", i, 64'(d_wen[i]), 64'd0);
            chk("rst_busy", i, 64'(d_busy[i]), 64'd0);
            chk("rst_done", i, 64'(d_done[i]), 64'd0);
            chk("rst_wAddr", i, 64'(d_addr[i]), 64'd0);
            chk("rst_wData", i, 64'(d_data[i]), 64'd0);
        end

        repeat (5) @(posedge clk);
        #2 pulse_start();
        wait_wens(5);
        pulse_start();
        wait_done();

        repeat ($urandom_range(0, 3)) @(posedge clk);
        #2 pulse_start();
        for (int i = 0; i < 2; i++)
            chk("done_drop", i, 64'(d_done[i]), 64'd0);
        wait_done();

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        snap[0] = total_w[0];
        snap[1] = total_w[1];
        repeat (100) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++)
            chk("idle_writes", i, 64'(total_w[i] - snap[i]), 64'd0);

        repeat ($urandom_range(0, 20)) @(posedge clk);
        #2 pulse_start();
        wait_wens(10);
        reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("mid_rst_wEn", i, 64'(d_wen[i]), 64'd0);
            chk("mid_rst_busy", i, 64'(d_busy[i]), 64'd0);
            chk("mid_rst_done", i, 64'(d_done[i]), 64'd0);
        end
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #2 pulse_start();
        wait_done();

        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(1, 30)) @(posedge clk);
            #2 pulse_start();
            for (int j = 0; j < 3; j++) begin
                repeat ($urandom_range(2, 15)) @(posedge clk);
                #2 pulse_start();
            end
            wait_done();
        end

        repeat (3) @(posedge clk);
        #2;
        chk("first_addr_ace1", 0, 64'(first_addr[0]), 64'd21);
        chk("first_addr_zero", 1, 64'(first_addr[1]), 64'd0);
        for (int i = 0; i < 2; i++)
            chk("deals_done", i, 64'(deals[i]), 64'd7);
        chk("probe_wrap_seen", 0, 64'(wraps[0] + wraps[1] > 0), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
